// File: rtl/team_06_sram_arbiter_if.sv
// Bus bundle between the two SRAM requesters, the arbiter and the wishbone manager CPU port.
interface team_06_sram_arbiter_if;
    // requester A (echo/reverb) and B (playback/record)
    logic        req_a,  req_b;
    logic        we_a,   we_b;
    logic [31:0] adr_a,  adr_b;
    logic [31:0] wdat_a, wdat_b;
    logic [3:0]  sel_a,  sel_b;
    logic        ack_a,  ack_b;
    logic [31:0] rdat_a, rdat_b;
    // manager CPU-side port
    logic [31:0] mgr_adr_o;
    logic [31:0] mgr_dat_o;
    logic [3:0]  mgr_sel_o;
    logic        mgr_write_o;
    logic        mgr_read_o;
    logic [31:0] mgr_rdat_i;
    logic        mgr_busy_i;
    // status
    logic [1:0]  grant_o;
    logic        timeout_o;

    // arbiter side
    modport slave (
        input  req_a, req_b, we_a, we_b, adr_a, adr_b, wdat_a, wdat_b, sel_a, sel_b,
        input  mgr_rdat_i, mgr_busy_i,
        output ack_a, ack_b, rdat_a, rdat_b,
        output mgr_adr_o, mgr_dat_o, mgr_sel_o, mgr_write_o, mgr_read_o,
        output grant_o, timeout_o
    );

    // requester/manager environment side
    modport master (
        output req_a, req_b, we_a, we_b, adr_a, adr_b, wdat_a, wdat_b, sel_a, sel_b,
        output mgr_rdat_i, mgr_busy_i,
        input  ack_a, ack_b, rdat_a, rdat_b,
        input  mgr_adr_o, mgr_dat_o, mgr_sel_o, mgr_write_o, mgr_read_o,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/team_06_sram_arbiter.sv
// Two-client arbiter for the single wishbone manager CPU port. A has priority,
// a saturating fairness counter forces a B grant after A_MAX_CONSEC A grants
// while B waits. Each transaction: latch, one-cycle strobe, track busy, ack.
module team_06_sram_arbiter #(
    parameter int A_MAX_CONSEC = 4,
    parameter int BUSY_WAIT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    team_06_sram_arbiter_if.slave bus
);
    localparam int CW = $clog2(A_MAX_CONSEC + 1);
    localparam int WW = $clog2(BUSY_WAIT + 1);
    localparam logic [CW-1:0] A_MAX_C = CW'(A_MAX_CONSEC);
    localparam logic [WW-1:0] BW_LAST = WW'(BUSY_WAIT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [1:0]    grant_q, grant_d;     // {B,A}, one-hot while a transaction is owned
    logic [CW-1:0] fcnt_q, fcnt_d;       // consecutive A grants while B pending
    logic [WW-1:0] wcnt_q, wcnt_d;       // cycles spent waiting for busy
    logic          timeout_q, timeout_d;
    logic [31:0]   rdat_a_q, rdat_a_d;
    logic [31:0]   rdat_b_q, rdat_b_d;
    logic          start, pick_a, cap;

    // A wins unless B is waiting and A has used up its consecutive budget
    assign start  = !bus.mgr_busy_i && (bus.req_a || bus.req_b);
    assign pick_a = bus.req_a && (!bus.req_b || (fcnt_q < A_MAX_C));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.mgr_busy_i)        state_d = WAIT_DONE;
                       else if (wcnt_q == BW_LAST) state_d = RESP;
            WAIT_DONE: if (!bus.mgr_busy_i) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // datapath next-state: request latch, fairness, busy wait, read capture
    always_comb begin
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        rdat_a_d  = rdat_a_q;
        rdat_b_d  = rdat_b_q;
        cap       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (pick_a) begin
                    we_d    = bus.we_a;
                    adr_d   = bus.adr_a;
                    dat_d   = bus.wdat_a;
                    sel_d   = bus.sel_a;
                    grant_d = 2'b01;
                    fcnt_d  = !bus.req_b ? '0 :
                              (fcnt_q == A_MAX_C) ? fcnt_q : fcnt_q + 1'b1;
                end else begin
                    we_d    = bus.we_b;
                    adr_d   = bus.adr_b;
                    dat_d   = bus.wdat_b;
                    sel_d   = bus.sel_b;
                    grant_d = 2'b10;
                    fcnt_d  = '0;
                end
            end
            ISSUE: wcnt_d = '0;
            WAIT_BUSY: if (!bus.mgr_busy_i) begin
                if (wcnt_q == BW_LAST) begin
                    timeout_d = 1'b1;
                    cap       = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            WAIT_DONE: if (!bus.mgr_busy_i) cap = 1'b1;
            RESP:      grant_d = '0;
            default: ;
        endcase
        // writes never touch the read-data registers
        if (cap && !we_q) begin
            if (grant_q[0]) rdat_a_d = bus.mgr_rdat_i;
            else            rdat_b_d = bus.mgr_rdat_i;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            fcnt_q    <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            rdat_a_q  <= '0;
            rdat_b_q  <= '0;
        end else begin
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            rdat_a_q  <= rdat_a_d;
            rdat_b_q  <= rdat_b_d;
        end
    end

    // outputs decoded from registered state; strobes and acks drop with async reset
    always_comb begin
        bus.mgr_write_o = (state_q == ISSUE) && we_q;
        bus.mgr_read_o  = (state_q == ISSUE) && !we_q;
        bus.ack_a       = (state_q == RESP) && grant_q[0];
        bus.ack_b       = (state_q == RESP) && grant_q[1];
        bus.mgr_adr_o   = adr_q;
        bus.mgr_dat_o   = dat_q;
        bus.mgr_sel_o   = sel_q;
        bus.grant_o     = grant_q;
        bus.timeout_o   = timeout_q;
        bus.rdat_a      = rdat_a_q;
        bus.rdat_b      = rdat_b_q;
    end
endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// Bench for team_06_sram_arbiter: behavioural SRAM manager plus a transaction-level
// reference (expected memory, per-requester held read data, grant-order rule).
module tb_team_06_sram_arbiter;
    localparam int BW   = 4;
    localparam int AMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    team_06_sram_arbiter_if bus();
    team_06_sram_arbiter #(.A_MAX_CONSEC(AMAX), .BUSY_WAIT(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nvec = 0, nerr = 0, cyc = 0;
    logic [31:0] sram    [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rdat_a = '0, exp_rdat_b = '0;

    // manager model controls
    int   busy_len = 1, busy_left = 0;
    bit   no_busy = 1'b0, force_busy = 1'b0;
    logic [31:0] rdat_q = '0;

    // results of the last run_txn
    bit          t_ok;
    int          t_nwr, t_nrd, t_oth, t_strb, t_ack;
    logic [1:0]  t_gnt;
    logic [31:0] t_adr, t_dat, t_adr_r, t_rd, t_ordat;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w, logic [3:0] s);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = s[k] ? w[k*8 +: 8] : o[k*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM manager: busy rises the cycle after a strobe and lasts busy_len cycles
    always @(posedge clk) begin
        if ((bus.mgr_write_o || bus.mgr_read_o) && !no_busy) begin
            busy_left <= busy_len;
            if (bus.mgr_write_o)
                sram[bus.mgr_adr_o[9:2]] <= merge(sram[bus.mgr_adr_o[9:2]], bus.mgr_dat_o, bus.mgr_sel_o);
            else
                rdat_q <= sram[bus.mgr_adr_o[9:2]];
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
    end
    assign bus.mgr_busy_i = force_busy || (busy_left != 0);
    assign bus.mgr_rdat_i = rdat_q;

    task automatic drive(input bit b, input bit we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
        if (b) begin bus.we_b = we; bus.adr_b = adr; bus.wdat_b = wd; bus.sel_b = sel; end
        else   begin bus.we_a = we; bus.adr_a = adr; bus.wdat_a = wd; bus.sel_a = sel; end
    endtask

    task automatic rand_op(output bit we, output logic [31:0] adr, output logic [31:0] wd, output logic [3:0] sel);
        we  = 1'($urandom_range(0, 1));
        adr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        wd  = $urandom;
        sel = 4'($urandom_range(1, 15));
    endtask

    // one transaction from one requester; records what was observed, no judging
    task automatic run_txn(input bit b, input bit we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
        @(negedge clk);
        drive(b, we, adr, wd, sel);
        if (b) bus.req_b = 1'b1; else bus.req_a = 1'b1;
        t_ok = 0; t_nwr = 0; t_nrd = 0; t_oth = 0; t_strb = -1; t_ack = -1; t_gnt = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mgr_write_o) t_nwr++;
            if (bus.mgr_read_o)  t_nrd++;
            if (bus.mgr_write_o || bus.mgr_read_o) begin
                t_strb = cyc; t_gnt = bus.grant_o; t_adr = bus.mgr_adr_o; t_dat = bus.mgr_dat_o;
            end
            if (b ? bus.ack_a : bus.ack_b) t_oth++;
            if (b ? bus.ack_b : bus.ack_a) begin
                t_ok = 1; t_ack = cyc; t_adr_r = bus.mgr_adr_o;
                t_rd = b ? bus.rdat_b : bus.rdat_a; t_ordat = b ? bus.rdat_a : bus.rdat_b;
                break;
            end
        end
        if (b) bus.req_b = 1'b0; else bus.req_a = 1'b0;
        if (t_ok && we) ref_mem[adr[9:2]] = merge(ref_mem[adr[9:2]], wd, sel);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++; if ({bus.ack_a, bus.ack_b, bus.mgr_write_o, bus.mgr_read_o, bus.grant_o, bus.timeout_o} !== 7'b0) begin
            nerr++; $display("FAIL reset_ctrl got=%b want=0", {bus.ack_a, bus.ack_b, bus.mgr_write_o, bus.mgr_read_o, bus.grant_o, bus.timeout_o}); end
        nvec++; if ({bus.mgr_adr_o, bus.mgr_dat_o, bus.mgr_sel_o} !== 68'h0) begin
            nerr++; $display("FAIL reset_bus got=%h %h %h want=0", bus.mgr_adr_o, bus.mgr_dat_o, bus.mgr_sel_o); end
        nvec++; if ({bus.rdat_a, bus.rdat_b} !== 64'h0) begin
            nerr++; $display("FAIL reset_rdat got=%h %h want=0", bus.rdat_a, bus.rdat_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_a();
        busy_len = 1;
        run_txn(0, 1, 32'h100, 32'hA5A5_0001, 4'hF);
        nvec++; if (!t_ok || t_oth != 0) begin nerr++; $display("FAIL wr_ack ok=%0d other_acks=%0d want ok=1 other=0", t_ok, t_oth); end
        nvec++; if (t_nwr != 1 || t_nrd != 0) begin nerr++; $display("FAIL wr_strobe writes=%0d reads=%0d want 1/0", t_nwr, t_nrd); end
        nvec++; if (t_gnt !== 2'b01) begin nerr++; $display("FAIL wr_grant got=%b want=01", t_gnt); end
        nvec++; if (t_adr !== 32'h100 || t_dat !== 32'hA5A5_0001 || t_adr_r !== 32'h100) begin
            nerr++; $display("FAIL wr_bus adr=%h dat=%h adr_at_ack=%h want 100/a5a50001/100", t_adr, t_dat, t_adr_r); end
        nvec++; if (sram[64] !== 32'hA5A5_0001) begin nerr++; $display("FAIL wr_mem got=%h want=a5a50001", sram[64]); end
        @(negedge clk);
        nvec++; if (bus.grant_o !== 2'b00) begin nerr++; $display("FAIL wr_grant_idle got=%b want=00", bus.grant_o); end
    endtask

    task automatic test_read_a();
        busy_len = 3;
        run_txn(0, 0, 32'h200, 32'h0, 4'hF);
        exp_rdat_a = 32'hDEAD_BEEF;
        nvec++; if (!t_ok || t_rd !== exp_rdat_a) begin nerr++; $display("FAIL rd_a ok=%0d got=%h want=deadbeef", t_ok, t_rd); end
        nvec++; if (t_ordat !== exp_rdat_b || t_nrd != 1 || t_nwr != 0) begin
            nerr++; $display("FAIL rd_a_side rdat_b=%h want=%h reads=%0d writes=%0d", t_ordat, exp_rdat_b, t_nrd, t_nwr); end
        busy_len = 2;
        run_txn(1, 0, 32'h100, 32'h0, 4'hF);
        exp_rdat_b = 32'hA5A5_0001;
        nvec++; if (!t_ok || t_rd !== exp_rdat_b || t_ordat !== exp_rdat_a || t_gnt !== 2'b10) begin
            nerr++; $display("FAIL rd_b ok=%0d got=%h rdat_a=%h grant=%b want a5a50001/deadbeef/10", t_ok, t_rd, t_ordat, t_gnt); end
    endtask

    task automatic test_random_single();
        bit b, we; logic [31:0] adr, wd, er; logic [3:0] sel;
        for (int i = 0; i < 16; i++) begin
            b = 1'($urandom_range(0, 1));
            rand_op(we, adr, wd, sel);
            busy_len = $urandom_range(1, 4);
            if (!we) begin
                if (b) exp_rdat_b = ref_mem[adr[9:2]]; else exp_rdat_a = ref_mem[adr[9:2]];
            end
            er = b ? exp_rdat_b : exp_rdat_a;
            run_txn(b, we, adr, wd, sel);
            nvec++; if (!t_ok || t_rd !== er || t_ordat !== (b ? exp_rdat_a : exp_rdat_b)) begin
                nerr++; $display("FAIL rand_%0d b=%0d we=%0d ok=%0d rdat=%h want=%h other=%h", i, b, we, t_ok, t_rd, er, t_ordat); end
            nvec++; if (t_gnt !== (b ? 2'b10 : 2'b01) || t_nwr != int'(we) || t_nrd != int'(!we)) begin
                nerr++; $display("FAIL rand_%0d_strobe grant=%b wr=%0d rd=%0d", i, t_gnt, t_nwr, t_nrd); end
        end
    endtask

    task automatic test_fairness();
        bit wa, wb; logic [31:0] aa, ab, da, db; logic [3:0] sa, sb;
        int got [10]; int n, cnt; bit eb;
        rand_op(wa, aa, da, sa); rand_op(wb, ab, db, sb);
        @(negedge clk);
        drive(0, wa, aa, da, sa); drive(1, wb, ab, db, sb);
        bus.req_a = 1'b1; bus.req_b = 1'b1;
        n = 0;
        for (int g = 0; g < 600 && n < 10; g++) begin
            @(negedge clk);
            if (bus.ack_a && bus.ack_b) begin nvec++; nerr++; $display("FAIL fair_double_ack at cycle %0d", cyc); end
            if (bus.ack_a) begin
                got[n] = 0; n++;
                if (!wa) exp_rdat_a = ref_mem[aa[9:2]]; else ref_mem[aa[9:2]] = merge(ref_mem[aa[9:2]], da, sa);
                nvec++; if (bus.rdat_a !== exp_rdat_a || bus.rdat_b !== exp_rdat_b) begin
                    nerr++; $display("FAIL fair_rdat_a got=%h/%h want=%h/%h", bus.rdat_a, bus.rdat_b, exp_rdat_a, exp_rdat_b); end
                rand_op(wa, aa, da, sa); drive(0, wa, aa, da, sa);
            end else if (bus.ack_b) begin
                got[n] = 1; n++;
                if (!wb) exp_rdat_b = ref_mem[ab[9:2]]; else ref_mem[ab[9:2]] = merge(ref_mem[ab[9:2]], db, sb);
                nvec++; if (bus.rdat_b !== exp_rdat_b || bus.rdat_a !== exp_rdat_a) begin
                    nerr++; $display("FAIL fair_rdat_b got=%h/%h want=%h/%h", bus.rdat_b, bus.rdat_a, exp_rdat_b, exp_rdat_a); end
                rand_op(wb, ab, db, sb); drive(1, wb, ab, db, sb);
            end
            if (n == 10) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
            busy_len = $urandom_range(1, 4);
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        // both always pending: A runs AMAX times in a row, then B once
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            eb = (cnt >= AMAX);
            cnt = eb ? 0 : cnt + 1;
            nvec++; if (i >= n || got[i] != int'(eb)) begin
                nerr++; $display("FAIL fair_order_%0d got=%s want=%s", i, (i >= n) ? "none" : (got[i] != 0 ? "B" : "A"), eb ? "B" : "A"); end
        end
    endtask

    task automatic test_busy_at_req();
        int strobes; bit ok; logic [1:0] g;
        force_busy = 1'b1; busy_len = 2; strobes = 0; g = '0; ok = 0;
        @(negedge clk);
        drive(1, 0, 32'h200, 32'h0, 4'hF); bus.req_b = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.mgr_read_o || bus.mgr_write_o) strobes++;
            g = g | bus.grant_o;
        end
        nvec++; if (strobes != 0 || g !== 2'b00) begin nerr++; $display("FAIL busy_hold strobes=%0d grant=%b want 0/00", strobes, g); end
        force_busy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mgr_read_o) strobes++;
            if (bus.ack_b) begin ok = 1; break; end
        end
        bus.req_b = 1'b0;
        exp_rdat_b = 32'hDEAD_BEEF;
        nvec++; if (!ok || strobes != 1 || bus.rdat_b !== exp_rdat_b) begin
            nerr++; $display("FAIL busy_release ok=%0d strobes=%0d rdat_b=%h want 1/1/deadbeef", ok, strobes, bus.rdat_b); end
    endtask

    task automatic test_timeout();
        no_busy = 1'b1;
        nvec++; if (bus.timeout_o !== 1'b0) begin nerr++; $display("FAIL to_pre got=%b want=0", bus.timeout_o); end
        run_txn(0, 1, 32'h3F0, 32'h1234_5678, 4'hF);
        nvec++; if (!t_ok || t_strb < 0 || (t_ack - t_strb) != BW + 1) begin
            nerr++; $display("FAIL to_latency ok=%0d strobe_to_ack=%0d want=%0d", t_ok, t_ack - t_strb, BW + 1); end
        nvec++; if (bus.timeout_o !== 1'b1 || t_rd !== exp_rdat_a) begin
            nerr++; $display("FAIL to_flag timeout=%b rdat_a=%h want 1/%h", bus.timeout_o, t_rd, exp_rdat_a); end
        no_busy = 1'b0; busy_len = 1;
        run_txn(0, 0, 32'h100, 32'h0, 4'hF);
        exp_rdat_a = 32'hA5A5_0001;
        nvec++; if (!t_ok || t_rd !== exp_rdat_a || bus.timeout_o !== 1'b1) begin
            nerr++; $display("FAIL to_sticky ok=%0d rdat_a=%h timeout=%b want 1/a5a50001/1", t_ok, t_rd, bus.timeout_o); end
    endtask

    task automatic test_reset_mid();
        bit seen; int acks;
        busy_len = 10; seen = 0; acks = 0;
        @(negedge clk);
        drive(0, 0, 32'h100, 32'h0, 4'hF); bus.req_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mgr_busy_i && bus.grant_o != 2'b00) begin seen = 1; break; end
        end
        @(negedge clk);
        nvec++; if (!seen || bus.grant_o !== 2'b01) begin nerr++; $display("FAIL rm_reach seen=%0d grant=%b want 1/01", seen, bus.grant_o); end
        rst_n = 1'b0;
        #1;
        nvec++; if ({bus.ack_a, bus.ack_b, bus.mgr_write_o, bus.mgr_read_o, bus.grant_o, bus.timeout_o} !== 7'b0) begin
            nerr++; $display("FAIL rm_ctrl got=%b want=0", {bus.ack_a, bus.ack_b, bus.mgr_write_o, bus.mgr_read_o, bus.grant_o, bus.timeout_o}); end
        nvec++; if ({bus.mgr_adr_o, bus.rdat_a, bus.rdat_b} !== 96'h0) begin
            nerr++; $display("FAIL rm_data adr=%h rdat_a=%h rdat_b=%h want=0", bus.mgr_adr_o, bus.rdat_a, bus.rdat_b); end
        repeat (3) begin @(negedge clk); if (bus.ack_a || bus.ack_b) acks++; end
        bus.req_a = 1'b0;
        rst_n = 1'b1;
        exp_rdat_a = '0; exp_rdat_b = '0;
        busy_len = 1;
        run_txn(1, 0, 32'h200, 32'h0, 4'hF);
        exp_rdat_b = 32'hDEAD_BEEF;
        nvec++; if (acks != 0 || t_oth != 0 || !t_ok) begin nerr++; $display("FAIL rm_acks stray=%0d other=%0d ok=%0d want 0/0/1", acks, t_oth, t_ok); end
        nvec++; if (t_rd !== exp_rdat_b || t_ordat !== exp_rdat_a || t_gnt !== 2'b10 || bus.timeout_o !== 1'b0) begin
            nerr++; $display("FAIL rm_fresh rdat_b=%h rdat_a=%h grant=%b timeout=%b want deadbeef/0/10/0", t_rd, t_ordat, t_gnt, bus.timeout_o); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        sram[128] = 32'hDEAD_BEEF; ref_mem[128] = 32'hDEAD_BEEF;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        drive(0, 0, '0, '0, '0); drive(1, 0, '0, '0, '0);
        test_reset();
        test_write_a();
        test_read_a();
        test_random_single();
        test_fairness();
        test_busy_at_req();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
